multicycle_controller: RTL and testbench

Multi-cycle sequencer for the RV32I-subset core (R-type, addi, lw, sw, beq/bne/blt, jal, jalr, lui). Each instruction runs through FETCH/DECODE/EXEC/MEM/WB states over a single shared instruction/data memory port with a req/ready handshake. The block drives the datapath's register enables, muxes and ALU op class, and halts on an illegal opcode or a memory timeout. It sits between the instruction register's opcode field and the datapath/memory port.

---
 rtl/mc_ctrl_pkg.sv | 69 ++++++
 rtl/mc_opcode_class.sv | 35 +++
 rtl/multicycle_controller.sv | 229 ++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mc_ctrl_pkg
// Shared types and constants for the multi-cycle RV32I-subset controller:
//   state_t     - sequencer states
//   OP_*        - the eight supported major opcodes (IR[6:0])
//   alu_op_t    - ALU operation class driven to the datapath
//   pc_src_t    - PC next-value select
//   wb_sel_t    - register file write-back source select
//   op_class_t  - decoded instruction class
//   cnt_width() - width of the memory timeout counter
// -----------------------------------------------------------------------------
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      FETCH  = 3'd0,
      DECODE = 3'd1,
      EXEC   = 3'd2,
      MEM    = 3'd3,
      WB     = 3'd4,
      HALT   = 3'd5
   } state_t;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ADDI   = 7'b0010011;
   localparam logic [6:0] OP_LW     = 7'b0000011;
   localparam logic [6:0] OP_SW     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef enum logic [1:0] {
      ALU_MEM    = 2'b00,   // address add for lw/sw
      ALU_BRANCH = 2'b01,   // compare for beq/bne/blt
      ALU_FUNCT  = 2'b10,   // funct3/funct7 selects the operation
      ALU_PASS   = 2'b11    // lui/jal/jalr
   } alu_op_t;

   typedef enum logic [1:0] {
      PC_PLUS4 = 2'b00,     // PC + 4
      PC_REL   = 2'b01,     // OLD_PC + imm
      PC_JALR  = 2'b10      // (rs1 + imm) & ~1
   } pc_src_t;

   typedef enum logic [1:0] {
      WB_ALU = 2'b00,
      WB_MDR = 2'b01,
      WB_PC  = 2'b10
   } wb_sel_t;

   typedef enum logic [2:0] {
      CLS_RTYPE,
      CLS_ADDI,
      CLS_LW,
      CLS_SW,
      CLS_BRANCH,
      CLS_JAL,
      CLS_JALR,
      CLS_LUI
   } op_class_t;

   // Counter must hold 0..timeout; a disabled timeout (0) still gets one bit.
   function automatic int cnt_width(input int timeout);
      int w;
      w = $clog2(timeout + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/mc_opcode_class.sv
// -----------------------------------------------------------------------------
// mc_opcode_class
// Combinational classification of the instruction register opcode field.
// Ports:
//   opcode   in  7  IR[6:0]
//   op_class out 3  instruction class (op_class_t)
//   legal    out 1  opcode is one of the eight supported major opcodes
// -----------------------------------------------------------------------------
module mc_opcode_class
   import mc_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_t  op_class,
   output logic       legal
);

   // NOTE: both outputs get a default before the case so that no opcode
   // value leaves them unassigned, which would otherwise infer a latch.
   always_comb begin
      op_class = CLS_RTYPE;
      legal    = 1'b1;
      case (opcode)
         OP_RTYPE:  op_class = CLS_RTYPE;
         OP_ADDI:   op_class = CLS_ADDI;
         OP_LW:     op_class = CLS_LW;
         OP_SW:     op_class = CLS_SW;
         OP_BRANCH: op_class = CLS_BRANCH;
         OP_JAL:    op_class = CLS_JAL;
         OP_JALR:   op_class = CLS_JALR;
         OP_LUI:    op_class = CLS_LUI;
         default:   legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// -----------------------------------------------------------------------------
// multicycle_controller
// FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I-subset core.
// One shared instruction/data memory port with a req/ready handshake; halts on
// an illegal opcode or when a request waits MEM_TIMEOUT cycles without ready.
// Parameters:
//   MEM_TIMEOUT   max consecutive unanswered request cycles (0 disables)
// Ports:
//   clk           in   core clock
//   reset         in   synchronous, active-high
//   opcode        in   IR[6:0], valid from DECODE onward
//   branch_taken  in   ALU compare result, used in EXEC
//   mem_ready     in   memory completes the current request this cycle
//   mem_req       out  memory request
//   mem_we        out  write strobe, qualified by mem_req
//   mem_addr_sel  out  0: PC, 1: ALU result
//   ir_write      out  load IR and OLD_PC
//   mdr_write     out  load memory data register
//   pc_write      out  load PC from pc_src
//   pc_src        out  next-PC select (pc_src_t)
//   alu_src       out  0: rs2, 1: immediate
//   alu_op        out  ALU operation class (alu_op_t)
//   reg_write     out  register file write enable
//   wb_sel        out  write-back source (wb_sel_t)
//   retire        out  one-cycle pulse on instruction completion
//   halted        out  core stopped (sticky until reset)
//   err_timeout   out  halt was caused by memory timeout (sticky)
// -----------------------------------------------------------------------------
module multicycle_controller
   import mc_ctrl_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255
)
(
   input  logic       clk,
   input  logic       reset,
   input  logic [6:0] opcode,
   input  logic       branch_taken,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_write,
   output logic       mdr_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src,
   output logic [1:0] alu_op,
   output logic       reg_write,
   output logic [1:0] wb_sel,
   output logic       retire,
   output logic       halted,
   output logic       err_timeout
);

   localparam int                CNT_W    = cnt_width(MEM_TIMEOUT);
   localparam bit                TMO_EN   = (MEM_TIMEOUT != 0);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  tmo_cnt;
   logic              err_timeout_q;

   op_class_t         op_class;
   logic              op_legal;

   logic              mem_wait;
   logic              timeout_hit;
   logic              cls_alu_src;
   alu_op_t           cls_alu_op;
   pc_src_t           pc_src_e;
   alu_op_t           alu_op_e;
   wb_sel_t           wb_sel_e;

   mc_opcode_class u_opcode_class (
      .opcode   (opcode),
      .op_class (op_class),
      .legal    (op_legal)
   );

   // A request cycle that the memory did not answer.
   assign mem_wait    = ((state == FETCH) || (state == MEM)) && !mem_ready;
   // ready on the last allowed cycle wins over the timeout.
   assign timeout_hit = TMO_EN && mem_wait && (tmo_cnt == CNT_LAST);

   // ALU controls per instruction class; used in EXEC and held through MEM.
   always_comb begin
      cls_alu_src = 1'b0;
      cls_alu_op  = ALU_FUNCT;
      case (op_class)
         CLS_RTYPE:  begin cls_alu_src = 1'b0; cls_alu_op = ALU_FUNCT;  end
         CLS_ADDI:   begin cls_alu_src = 1'b1; cls_alu_op = ALU_FUNCT;  end
         CLS_LW,
         CLS_SW:     begin cls_alu_src = 1'b1; cls_alu_op = ALU_MEM;    end
         CLS_BRANCH: begin cls_alu_src = 1'b0; cls_alu_op = ALU_BRANCH; end
         CLS_JAL,
         CLS_JALR,
         CLS_LUI:    begin cls_alu_src = 1'b1; cls_alu_op = ALU_PASS;   end
         default:    ;
      endcase
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (mem_ready)        state_next = DECODE;
            else if (timeout_hit) state_next = HALT;
         end
         DECODE: state_next = op_legal ? EXEC : HALT;
         EXEC: begin
            case (op_class)
               CLS_LW, CLS_SW: state_next = MEM;
               CLS_BRANCH:     state_next = FETCH;
               default:        state_next = WB;
            endcase
         end
         MEM: begin
            if (mem_ready)        state_next = (op_class == CLS_SW) ? FETCH : WB;
            else if (timeout_hit) state_next = HALT;
         end
         WB:      state_next = FETCH;
         HALT:    state_next = HALT;
         default: state_next = HALT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= FETCH;
         tmo_cnt       <= '0;
         err_timeout_q <= 1'b0;
      end else begin
         state <= state_next;
         // Any state change restarts the wait count for the next request.
         if (state_next != state)
            tmo_cnt <= '0;
         else if (TMO_EN && mem_wait)
            tmo_cnt <= tmo_cnt + CNT_W'(1);
         if (timeout_hit)
            err_timeout_q <= 1'b1;
      end
   end

   // Output decode. Everything is forced low while reset is high so an
   // in-flight request is withdrawn in the reset cycle itself.
   always_comb begin
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      mdr_write    = 1'b0;
      pc_write     = 1'b0;
      pc_src_e     = PC_PLUS4;
      alu_src      = 1'b0;
      alu_op_e     = ALU_MEM;
      reg_write    = 1'b0;
      wb_sel_e     = WB_ALU;
      retire       = 1'b0;
      halted       = 1'b0;
      err_timeout  = 1'b0;
      if (!reset) begin
         case (state)
            FETCH: begin
               mem_req = 1'b1;
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
               end
            end
            DECODE: ;
            EXEC: begin
               alu_src  = cls_alu_src;
               alu_op_e = cls_alu_op;
               case (op_class)
                  CLS_BRANCH: begin
                     pc_write = branch_taken;
                     pc_src_e = PC_REL;
                     retire   = 1'b1;
                  end
                  CLS_JAL: begin
                     pc_write = 1'b1;
                     pc_src_e = PC_REL;
                  end
                  CLS_JALR: begin
                     pc_write = 1'b1;
                     pc_src_e = PC_JALR;
                  end
                  default: ;
               endcase
            end
            MEM: begin
               mem_req      = 1'b1;
               mem_addr_sel = 1'b1;
               mem_we       = (op_class == CLS_SW);
               alu_src      = cls_alu_src;
               alu_op_e     = cls_alu_op;
               if (mem_ready) begin
                  if (op_class == CLS_SW) retire    = 1'b1;
                  else                    mdr_write = 1'b1;
               end
            end
            WB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
               case (op_class)
                  CLS_LW:            wb_sel_e = WB_MDR;
                  CLS_JAL, CLS_JALR: wb_sel_e = WB_PC;
                  default:           wb_sel_e = WB_ALU;
               endcase
            end
            HALT: begin
               halted      = 1'b1;
               err_timeout = err_timeout_q;
            end
            default: ;
         endcase
      end
   end

   assign pc_src = pc_src_e;
   assign alu_op = alu_op_e;
   assign wb_sel = wb_sel_e;

endmodule

// File: tb/tb_multicycle_controller.sv
// -----------------------------------------------------------------------------
// tb_multicycle_controller
// Scoreboard bench: each instruction pushes its per-cycle stimulus and the
// expected 17-bit output vector; the drain loop drives one entry per cycle and
// compares the DUT outputs against the popped expectation.
// Output vector order:
//   {mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write, pc_src[1:0],
//    alu_src, alu_op[1:0], reg_write, wb_sel[1:0], retire, halted, err_timeout}
// -----------------------------------------------------------------------------
module tb_multicycle_controller;

   localparam logic [6:0] O_R    = 7'b0110011;
   localparam logic [6:0] O_ADDI = 7'b0010011;
   localparam logic [6:0] O_LW   = 7'b0000011;
   localparam logic [6:0] O_SW   = 7'b0100011;
   localparam logic [6:0] O_BR   = 7'b1100011;
   localparam logic [6:0] O_JAL  = 7'b1101111;
   localparam logic [6:0] O_JALR = 7'b1100111;
   localparam logic [6:0] O_LUI  = 7'b0110111;
   localparam logic [6:0] O_ILL  = 7'b0000000;

   localparam logic [16:0] M_REQ  = 17'h10000;
   localparam logic [16:0] M_WE   = 17'h08000;
   localparam logic [16:0] M_ASEL = 17'h04000;
   localparam logic [16:0] M_IRW  = 17'h02000;
   localparam logic [16:0] M_MDRW = 17'h01000;
   localparam logic [16:0] M_PCW  = 17'h00800;
   localparam logic [16:0] M_ASRC = 17'h00100;
   localparam logic [16:0] M_RW   = 17'h00020;
   localparam logic [16:0] M_RET  = 17'h00004;
   localparam logic [16:0] M_HLT  = 17'h00002;
   localparam logic [16:0] M_TMO  = 17'h00001;

   function automatic logic [16:0] ps(input int v); return 17'(v) << 9; endfunction
   function automatic logic [16:0] ao(input int v); return 17'(v) << 6; endfunction
   function automatic logic [16:0] wb(input int v); return 17'(v) << 3; endfunction

   typedef struct {
      logic        rst;
      logic [6:0]  op;
      logic        rdy;
      logic        tkn;
      logic [16:0] exp;
      string       tag;
   } step_t;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] opcode;
   logic       branch_taken;
   logic       mem_ready;
   logic       mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write;
   logic [1:0] pc_src, alu_op, wb_sel;
   logic       alu_src, reg_write, retire, halted, err_timeout;
   logic [16:0] obs;

   step_t q[$];
   int    n_tests = 0;
   int    n_fail  = 0;

   always #5 clk = ~clk;

   multicycle_controller #(.MEM_TIMEOUT(4)) dut (
      .clk          (clk),
      .reset        (reset),
      .opcode       (opcode),
      .branch_taken (branch_taken),
      .mem_ready    (mem_ready),
      .mem_req      (mem_req),
      .mem_we       (mem_we),
      .mem_addr_sel (mem_addr_sel),
      .ir_write     (ir_write),
      .mdr_write    (mdr_write),
      .pc_write     (pc_write),
      .pc_src       (pc_src),
      .alu_src      (alu_src),
      .alu_op       (alu_op),
      .reg_write    (reg_write),
      .wb_sel       (wb_sel),
      .retire       (retire),
      .halted       (halted),
      .err_timeout  (err_timeout)
   );

   assign obs = {mem_req, mem_we, mem_addr_sel, ir_write, mdr_write, pc_write, pc_src,
                 alu_src, alu_op, reg_write, wb_sel, retire, halted, err_timeout};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %05h expected %05h", tag, got, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [6:0] op, input logic rdy,
                      input logic tkn, input logic [16:0] exp, input string tag);
      step_t s;
      s.rst = rst; s.op = op; s.rdy = rdy; s.tkn = tkn; s.exp = exp; s.tag = tag;
      q.push_back(s);
   endtask

   // Expected cycle-by-cycle behaviour of one instruction, starting in FETCH.
   task automatic push_instr(input string name, input logic [6:0] op, input int fw,
                             input int mw, input logic tkn);
      logic [16:0] ex, mem_b, wbv;
      bit          has_mem, has_wb;
      has_mem = 1'b0;
      has_wb  = 1'b1;
      mem_b   = M_REQ | M_ASEL | M_ASRC;
      wbv     = M_RW | M_RET;
      ex      = '0;
      case (op)
         O_R:    ex = ao(2);
         O_ADDI: ex = M_ASRC | ao(2);
         O_LUI:  ex = M_ASRC | ao(3);
         O_LW:   begin ex = M_ASRC; has_mem = 1'b1; wbv = wbv | wb(1); end
         O_SW:   begin ex = M_ASRC; has_mem = 1'b1; has_wb = 1'b0; mem_b = mem_b | M_WE; end
         O_BR:   begin ex = ao(1) | ps(1) | M_RET | (tkn ? M_PCW : 17'h0); has_wb = 1'b0; end
         O_JAL:  begin ex = M_ASRC | ao(3) | M_PCW | ps(1); wbv = wbv | wb(2); end
         O_JALR: begin ex = M_ASRC | ao(3) | M_PCW | ps(2); wbv = wbv | wb(2); end
         default: ex = '0;
      endcase
      for (int i = 0; i < fw; i++) add(1'b0, op, 1'b0, tkn, M_REQ, {name, ":fetch_wait"});
      add(1'b0, op, 1'b1, tkn, M_REQ | M_IRW | M_PCW, {name, ":fetch"});
      add(1'b0, op, 1'b1, tkn, 17'h0, {name, ":decode"});
      add(1'b0, op, 1'b1, tkn, ex, {name, ":exec"});
      if (has_mem) begin
         for (int i = 0; i < mw; i++) add(1'b0, op, 1'b0, tkn, mem_b, {name, ":mem_wait"});
         add(1'b0, op, 1'b1, tkn, mem_b | ((op == O_SW) ? M_RET : M_MDRW), {name, ":mem"});
      end
      if (has_wb) add(1'b0, op, 1'b1, tkn, wbv, {name, ":wb"});
   endtask

   // Drive one queued step per cycle; sample 1 time unit after the falling edge.
   task automatic drain();
      step_t s;
      while (q.size() > 0) begin
         s = q.pop_front();
         @(negedge clk);
         reset        = s.rst;
         opcode       = s.op;
         mem_ready    = s.rdy;
         branch_taken = s.tkn;
         #1;
         check(s.tag, 32'(obs), 32'(s.exp));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; opcode = O_R; mem_ready = 1'b0; branch_taken = 1'b0;

      // Reset with ready high: still fully idle.
      add(1'b1, O_R, 1'b1, 1'b0, 17'h0, "reset0");
      add(1'b1, O_R, 1'b1, 1'b0, 17'h0, "reset1");

      // Zero-wait instruction mix.
      push_instr("add",     O_R,    0, 0, 1'b0);
      push_instr("addi",    O_ADDI, 0, 0, 1'b0);
      push_instr("lui",     O_LUI,  0, 0, 1'b0);
      push_instr("lw_w2",   O_LW,   0, 2, 1'b0);
      push_instr("sw",      O_SW,   0, 0, 1'b0);
      push_instr("beq_nt",  O_BR,   0, 0, 1'b0);
      push_instr("beq_t",   O_BR,   0, 0, 1'b1);
      push_instr("jal",     O_JAL,  0, 0, 1'b0);
      push_instr("jalr",    O_JALR, 0, 0, 1'b0);
      push_instr("sw_w1",   O_SW,   0, 1, 1'b0);
      push_instr("add_fw1", O_R,    1, 0, 1'b0);
      // Three waits in each request state: counter restarts between them.
      push_instr("lw_w3w3", O_LW,   3, 3, 1'b0);
      // Ready on the last allowed cycle completes normally.
      push_instr("add_fw3", O_R,    3, 0, 1'b0);
      drain();

      // Timeout in FETCH: halt after the 4th unanswered request cycle.
      for (int i = 0; i < 4; i++) add(1'b0, O_R, 1'b0, 1'b0, M_REQ, "tmo_fetch_wait");
      for (int i = 0; i < 3; i++) add(1'b0, O_R, 1'b1, 1'b0, M_HLT | M_TMO, "tmo_fetch_halt");
      add(1'b1, O_R, 1'b0, 1'b0, 17'h0, "tmo_fetch_reset");
      push_instr("add_after_tmo", O_R, 0, 0, 1'b0);

      // Timeout in MEM.
      add(1'b0, O_LW, 1'b1, 1'b0, M_REQ | M_IRW | M_PCW, "tmo_mem:fetch");
      add(1'b0, O_LW, 1'b1, 1'b0, 17'h0, "tmo_mem:decode");
      add(1'b0, O_LW, 1'b1, 1'b0, M_ASRC, "tmo_mem:exec");
      for (int i = 0; i < 4; i++) add(1'b0, O_LW, 1'b0, 1'b0, M_REQ | M_ASEL | M_ASRC, "tmo_mem:wait");
      for (int i = 0; i < 2; i++) add(1'b0, O_LW, 1'b1, 1'b0, M_HLT | M_TMO, "tmo_mem:halt");
      add(1'b1, O_LW, 1'b1, 1'b0, 17'h0, "tmo_mem:reset");

      // Reset during a MEM wait withdraws the request in that cycle.
      add(1'b0, O_LW, 1'b1, 1'b0, M_REQ | M_IRW | M_PCW, "rst_mid:fetch");
      add(1'b0, O_LW, 1'b1, 1'b0, 17'h0, "rst_mid:decode");
      add(1'b0, O_LW, 1'b1, 1'b0, M_ASRC, "rst_mid:exec");
      add(1'b0, O_LW, 1'b0, 1'b0, M_REQ | M_ASEL | M_ASRC, "rst_mid:mem_wait");
      add(1'b1, O_LW, 1'b0, 1'b0, 17'h0, "rst_mid:reset");
      push_instr("add_after_rst", O_R, 0, 0, 1'b0);

      // Illegal opcode: halt after DECODE, no requests, no timeout flag.
      add(1'b0, O_ILL, 1'b1, 1'b0, M_REQ | M_IRW | M_PCW, "ill:fetch");
      add(1'b0, O_ILL, 1'b1, 1'b0, 17'h0, "ill:decode");
      for (int i = 0; i < 20; i++) add(1'b0, O_ILL, 1'b1, 1'b0, M_HLT, "ill:halt");
      add(1'b1, O_ILL, 1'b1, 1'b0, 17'h0, "ill:reset");
      push_instr("jalr_after_ill", O_JALR, 0, 0, 1'b0);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
